logic_serial_nb: RTL and testbench
==================================

Name: logic_serial_nb

Overview:
Parametrised, bit-serial successor to the 1-bit NOR slice. It accepts two WIDTH-bit operands plus a carry-in and a 3-bit op select. It evaluates one bit per clock through a single internal 1-bit slice, then presents the WIDTH-bit result and carry-out with a start/busy/done handshake. It sits in the step-2 datapath as the shared logic/arithmetic unit ahead of the full ALU.

Parameters:
WIDTH, 8, operand/result width in bits (legal 2..32)
CNT_W, $clog2(WIDTH)+1, bit-counter width (derived; not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
op  input  3  operation select, latched on accept
x  input  WIDTH  operand A, latched on accept
y  input  WIDTH  operand B, latched on accept
ci  input  1  carry-in, latched on accept
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse when result is valid
out  output  WIDTH  result; held stable from done until next accept
co  output  1  carry-out for ADD/SUB, 0 for logic ops

Behaviour:
- Reset (rst_n low, asynchronous, any state): state=IDLE, busy=0, done=0, out=0, co=0, counter=0, operand/shift registers=0. Reset mid-operation aborts with no done pulse. First accept is possible on the first edge after rst_n rises.
- States: IDLE, RUN.
  - IDLE -> RUN on an edge with start=1.
  - RUN -> IDLE on the edge that processes bit WIDTH-1.
- Accept edge (k):
  - Latch x, y, op, ci into shift registers A, B, OP_R and carry register C.
  - For SUB, B latches ~y and C latches 1; ci is ignored.
  - busy=1, counter=0, done=0.
- Edges k+1 .. k+WIDTH:
  - Slice evaluates bit i=counter from A[0], B[0], C.
  - Result bit shifts into the MSB of the result shift register; A and B shift right.
  - For ADD/SUB, C becomes the slice carry.
  - counter increments.
- Edge k+WIDTH (last bit):
  - Full result is copied to out; co=C_final for op 6/7, else 0.
  - busy=0, done=1, state=IDLE.
- Edge k+WIDTH+1: done=0 unless a new job just finished (impossible; minimum job length WIDTH+1 edges).
- Latency: done is high in the cycle following edge k+WIDTH, i.e. WIDTH cycles after accept. Throughput is one job per WIDTH+1 cycles when start is held high.
- start while busy=1: ignored, no queuing; inputs may change freely while busy.
- start=1 in the done cycle (state IDLE): accepted on that edge. done still drops at that edge; out holds the old result until the new job's last edge.
- out/co are never updated mid-job (no partial results visible).
- Op encoding (per bit):
  - 0 NOR: ~(a|b)
  - 1 OR: a|b
  - 2 AND: a&b
  - 3 NAND: ~(a&b)
  - 4 XOR: a^b
  - 5 XNOR: ~(a^b)
  - 6 ADD: a^b^c, carry = majority(a,b,c)
  - 7 SUB: as ADD with b=~y bit, c0=1
- Arithmetic width rules:
  - Result is truncated to WIDTH bits.
  - co is the carry out of bit WIDTH-1.
  - SUB co=1 means no borrow (x>=y unsigned).
- ci is ignored for ops 0-5 and 7.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with start=1 -> busy=0, done=0, out=0, co=0 throughout. Release; start=1, op=0, x=8'h00, y=8'h00 -> done after 8 cycles, out=8'hFF, co=0.
- NOR/logic sweep (WIDTH=8): x=8'hA5, y=8'h3C, ops 0..5 back-to-back via start-in-done-cycle -> out = 8'h42, 8'hBD, 8'h24, 8'hDB, 8'h99, 8'h66. done pulses exactly 6 times, each 9 edges apart; busy high 8 cycles per job.
- ADD with carry: op=6, x=8'hFF, y=8'h01, ci=0 -> out=8'h00, co=1. Then x=8'h7F, y=8'h00, ci=1 -> out=8'h80, co=0.
- SUB: op=7, x=8'h10, y=8'h01, ci=1 -> out=8'h0F, co=1. Then x=8'h01, y=8'h02 -> out=8'hFF, co=0.
- Busy protection: start op=6, x=3, y=4, ci=0; in cycle 3 of RUN drive start=1, op=0, x=8'hFF, y=8'hFF -> ignored; single done with out=8'h07, co=0; out unchanged before done.
- Reset mid-op: start op=6, x=8'hFF, y=8'hFF; pulse rst_n low at cycle 4 of RUN (between edges) -> busy/out/co clear immediately, no done pulse. A following job x=2, y=2, op=6 -> out=8'h04.

Source files
------------

// File: rtl/logic_serial_nb.sv
// rtl/logic_serial_nb.sv - bit-serial logic/arithmetic unit: one bit per clock through a shared 1-bit slice
module logic_serial_nb #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             co
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  localparam logic [2:0] OP_NOR  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_ADD  = 3'd6;
  localparam logic [2:0] OP_SUB  = 3'd7;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic [2:0]       op_r;
  logic             c_r;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             last_bit;
  logic             arith;
  logic             slice_r;
  logic             slice_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (cnt == LAST_BIT) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    busy     = (state_q == RUN);
    accept   = (state_q == IDLE) && start;
    last_bit = (state_q == RUN) && (cnt == LAST_BIT);
    arith    = (op_r == OP_ADD) || (op_r == OP_SUB);
  end

  // The shared 1-bit slice; SUB relies on B already holding ~y and C seeded with 1
  always_comb begin
    slice_r = 1'b0;
    slice_c = 1'b0;
    case (op_r)
      OP_NOR:  slice_r = ~(a_sr[0] | b_sr[0]);
      OP_OR:   slice_r = a_sr[0] | b_sr[0];
      OP_AND:  slice_r = a_sr[0] & b_sr[0];
      OP_NAND: slice_r = ~(a_sr[0] & b_sr[0]);
      OP_XOR:  slice_r = a_sr[0] ^ b_sr[0];
      OP_XNOR: slice_r = ~(a_sr[0] ^ b_sr[0]);
      OP_ADD, OP_SUB: begin
        slice_r = a_sr[0] ^ b_sr[0] ^ c_r;
        slice_c = (a_sr[0] & b_sr[0]) | (a_sr[0] & c_r) | (b_sr[0] & c_r);
      end
      default: slice_r = 1'b0;
    endcase
  end

  assign res_next = {slice_r, res_sr[WIDTH-1:1]};

  // Operand, result and counter datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      op_r   <= '0;
      c_r    <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sr   <= x;
      b_sr   <= (op == OP_SUB) ? ~y : y;
      c_r    <= (op == OP_SUB) ? 1'b1 : ci;
      op_r   <= op;
      res_sr <= '0;
      cnt    <= '0;
    end else if (state_q == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_next;
      cnt    <= cnt + CNT_W'(1);
      if (arith) c_r <= slice_c;
    end
  end

  // Published result only changes on the last bit, so no partial value is ever visible
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out  <= '0;
      co   <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= last_bit;
      if (last_bit) begin
        out <= res_next;
        co  <= arith ? slice_c : 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_logic_serial_nb.sv
// tb/tb_logic_serial_nb.sv - scoreboard bench for logic_serial_nb
module tb_logic_serial_nb;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             co;

  int checks;
  int errors;
  int done_cnt;
  logic [WIDTH:0] exp_q[$];

  logic_serial_nb #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .x     (x),
    .y     (y),
    .ci    (ci),
    .busy  (busy),
    .done  (done),
    .out   (out),
    .co    (co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // Reference: whole-word arithmetic, {co, out}
  function automatic logic [WIDTH:0] model(input logic [2:0] o, input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b, input logic c);
    logic [WIDTH:0] r;
    case (o)
      3'd0: r = {1'b0, ~(a | b)};
      3'd1: r = {1'b0, a | b};
      3'd2: r = {1'b0, a & b};
      3'd3: r = {1'b0, ~(a & b)};
      3'd4: r = {1'b0, a ^ b};
      3'd5: r = {1'b0, ~(a ^ b)};
      3'd6: r = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
      default: r = {1'b0, a} + {1'b0, ~b} + 1;
    endcase
    return r;
  endfunction

  task automatic launch(input logic [2:0] o, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic c);
    op = o; x = a; y = b; ci = c; start = 1'b1;
    exp_q.push_back(model(o, a, b, c));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called n_init negedges after the start drive; returns on the done negedge
  task automatic collect(input string name, input int n_init);
    int n;
    int bc;
    logic seen;
    logic stable;
    logic [WIDTH-1:0] held;
    logic [WIDTH:0] e;
    n = n_init; bc = n_init - 1; seen = 1'b0; stable = 1'b1; held = out;
    while (n < 40) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (busy === 1'b1) bc++;
      if (out !== held) stable = 1'b0;
      @(negedge clk);
      n++;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s timeout: done not seen within %0d cycles", name, n);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      checks += 4;
      if (out !== e[WIDTH-1:0]) begin
        errors++;
        $display("FAIL %s out: got %h expected %h", name, out, e[WIDTH-1:0]);
      end
      if (co !== e[WIDTH]) begin
        errors++;
        $display("FAIL %s co: got %b expected %b", name, co, e[WIDTH]);
      end
      if (n !== WIDTH + 1 || bc !== WIDTH) begin
        errors++;
        $display("FAIL %s timing: done at %0d busy %0d expected %0d busy %0d", name, n, bc, WIDTH + 1, WIDTH);
      end
      if (!stable) begin
        errors++;
        $display("FAIL %s out_stable: out changed before done, expected %h held", name, held);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1; start = 1'b1; op = 3'd6; x = 8'hFF; y = 8'hFF; ci = 1'b1;
    #1 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || out !== '0 || co !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: busy %b done %b out %h co %b expected 0 0 00 0", busy, done, out, co);
      end
    end
    rst_n = 1'b1;
    launch(3'd0, 8'h00, 8'h00, 1'b0);
    collect("reset_first_job", 1);
  endtask

  task automatic test_logic_sweep;
    int dc0;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    a = 8'hA5; b = 8'h3C;
    @(negedge clk);
    dc0 = done_cnt;
    for (int i = 0; i < 6; i++) begin
      launch(3'(i), a, b, 1'b1);
      collect($sformatf("sweep_op%0d", i), 1);
    end
    @(negedge clk);
    checks += 2;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL sweep_done_pulse: done %b expected 0", done);
    end
    if (done_cnt - dc0 !== 6) begin
      errors++;
      $display("FAIL sweep_done_count: got %0d expected 6", done_cnt - dc0);
    end
  endtask

  task automatic test_add_sub;
    logic [2:0] ops [4] = '{3'd6, 3'd6, 3'd7, 3'd7};
    logic [WIDTH-1:0] xs [4] = '{8'hFF, 8'h7F, 8'h10, 8'h01};
    logic [WIDTH-1:0] ys [4] = '{8'h01, 8'h00, 8'h01, 8'h02};
    logic cis [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      launch(ops[i], xs[i], ys[i], cis[i]);
      collect($sformatf("arith_%0d", i), 1);
    end
  endtask

  task automatic test_busy_protect;
    int dc0;
    @(negedge clk);
    dc0 = done_cnt;
    launch(3'd6, 8'd3, 8'd4, 1'b0);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; op = 3'd0; x = 8'hFF; y = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    collect("busy_protect", 4);
    repeat (12) @(negedge clk);
    checks++;
    if (done_cnt - dc0 !== 1) begin
      errors++;
      $display("FAIL busy_single_done: got %0d done pulses expected 1", done_cnt - dc0);
    end
  endtask

  task automatic test_reset_mid_op;
    int dc0;
    @(negedge clk);
    launch(3'd6, 8'hFF, 8'hFF, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || out !== '0 || co !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset: busy %b done %b out %h co %b expected 0 0 00 0", busy, done, out, co);
    end
    void'(exp_q.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    dc0 = done_cnt;
    repeat (12) @(negedge clk);
    checks++;
    if (done_cnt !== dc0) begin
      errors++;
      $display("FAIL midop_no_done: got %0d done pulses expected 0", done_cnt - dc0);
    end
    launch(3'd6, 8'd2, 8'd2, 1'b0);
    collect("after_reset_add", 1);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_empty: %0d left expected 0", exp_q.size());
    end
  endtask

  initial begin
    checks = 0; errors = 0; done_cnt = 0;
    start = 1'b0; op = '0; x = '0; y = '0; ci = 1'b0; rst_n = 1'b1;
    test_reset();
    test_logic_sweep();
    test_add_sub();
    test_busy_protect();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
